// File: rtl/channel_pulse_detector.sv
// Threshold-crossing pulse detector: tracks peak, width and start timestamp of each pulse
// and presents one registered event record per pulse over a valid/ready handshake.
module channel_pulse_detector #(
    parameter int TS_WIDTH  = 16,
    parameter int MIN_WIDTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_Enable,
    input  logic [7:0]          i_AdcSample,
    input  logic [7:0]          i_Threshold,
    input  logic                i_Ready,
    output logic                o_Valid,
    output logic [7:0]          o_Peak,
    output logic [7:0]          o_Width,
    output logic [TS_WIDTH-1:0] o_Timestamp,
    output logic [7:0]          o_Missed,
    output logic                o_Busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_REPORT
    } state_e;

    localparam logic [7:0] MIN_W = 8'(MIN_WIDTH);

    state_e              state_q, state_d;
    logic [TS_WIDTH-1:0] ts_cnt_q, ts_cnt_d;
    logic                prev_above_q;
    logic [7:0]          peak_q, peak_d;
    logic [7:0]          width_q, width_d;
    logic [TS_WIDTH-1:0] start_ts_q, start_ts_d;
    logic [7:0]          rec_peak_q, rec_peak_d;
    logic [7:0]          rec_width_q, rec_width_d;
    logic [TS_WIDTH-1:0] rec_ts_q, rec_ts_d;
    logic [7:0]          missed_q, missed_d;
    logic                valid_q, busy_q;
    logic                above, rise;

    assign above    = (i_AdcSample > i_Threshold);
    assign rise     = above && !prev_above_q;
    assign ts_cnt_d = ts_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        peak_d      = peak_q;
        width_d     = width_q;
        start_ts_d  = start_ts_q;
        rec_peak_d  = rec_peak_q;
        rec_width_d = rec_width_q;
        rec_ts_d    = rec_ts_q;
        missed_d    = missed_q;
        case (state_q)
            S_IDLE: begin
                if (i_Enable && rise) begin
                    state_d    = S_ACTIVE;
                    start_ts_d = ts_cnt_q;
                    peak_d     = i_AdcSample;
                    width_d    = 8'd1;
                end
            end
            S_ACTIVE: begin
                // Disable wins over the sample compare and drops the pulse silently.
                if (!i_Enable) begin
                    state_d = S_IDLE;
                end else if (above) begin
                    if (width_q != 8'hFF) width_d = width_q + 8'd1;
                    if (i_AdcSample > peak_q) peak_d = i_AdcSample;
                end else if (width_q >= MIN_W) begin
                    state_d     = S_REPORT;
                    rec_peak_d  = peak_q;
                    rec_width_d = width_q;
                    rec_ts_d    = start_ts_q;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REPORT: begin
                if (rise && missed_q != 8'hFF) missed_d = missed_q + 8'd1;
                if (i_Ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ts_cnt_q     <= '0;
            prev_above_q <= 1'b1;
            peak_q       <= '0;
            width_q      <= '0;
            start_ts_q   <= '0;
            rec_peak_q   <= '0;
            rec_width_q  <= '0;
            rec_ts_q     <= '0;
            missed_q     <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ts_cnt_q     <= ts_cnt_d;
            prev_above_q <= above;
            peak_q       <= peak_d;
            width_q      <= width_d;
            start_ts_q   <= start_ts_d;
            rec_peak_q   <= rec_peak_d;
            rec_width_q  <= rec_width_d;
            rec_ts_q     <= rec_ts_d;
            missed_q     <= missed_d;
            valid_q      <= (state_d == S_REPORT);
            busy_q       <= (state_d != S_IDLE);
        end
    end

    assign o_Valid     = valid_q;
    assign o_Busy      = busy_q;
    assign o_Peak      = rec_peak_q;
    assign o_Width     = rec_width_q;
    assign o_Timestamp = rec_ts_q;
    assign o_Missed    = missed_q;

endmodule
